// File: rtl/scope_capture_ctrl.sv
// Capture sequencer: decimates the ADC sample stream, detects an edge (or forced)
// trigger and writes a pre/post-trigger record of DEPTH samples into a circular RAM.
module scope_capture_ctrl #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10,
  parameter int DEC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [DEC_W-1:0]  decim,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  // NOTE: the encoding is {done, busy, state[1:0]}, so the status outputs are
  // plain register bits and need no decode logic behind them.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_PRE  = 4'b0101,
    S_WAIT = 4'b0110,
    S_POST = 4'b0111,
    S_DONE = 4'b1000
  } fsm_t;

  fsm_t              fsm;
  logic [DEC_W-1:0]  dec_cnt;
  logic [DEC_W-1:0]  decim_l;
  logic [ADDR_W-1:0] pretrig_l;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              force_pending;

  logic accepted;
  logic rise_hit;
  logic fall_hit;
  logic edge_hit;
  logic is_trig;

  assign done  = fsm[3];
  assign busy  = fsm[2];
  assign state = fsm[1:0];

  assign accepted = sample_valid && (dec_cnt == '0);
  assign rise_hit = ($signed(prev) <  $signed(trig_level)) &&
                    ($signed(sample) >= $signed(trig_level));
  assign fall_hit = ($signed(prev) >  $signed(trig_level)) &&
                    ($signed(sample) <= $signed(trig_level));
  assign edge_hit = prev_valid && (trig_rising ? rise_hit : fall_hit);
  // A force pulse arriving together with the sample counts as already pending.
  assign is_trig  = accepted && (force_pending || force_trig || edge_hit);

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm           <= S_IDLE;
      dec_cnt       <= '0;
      decim_l       <= '0;
      pretrig_l     <= '0;
      ptr           <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      force_pending <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      trig_addr     <= '0;
      start_addr    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (arm) begin
        fsm           <= S_PRE;
        pretrig_l     <= pretrig;
        decim_l       <= decim;
        dec_cnt       <= '0;
        ptr           <= '0;
        pre_cnt       <= '0;
        post_cnt      <= '0;
        prev_valid    <= 1'b0;
        force_pending <= 1'b0;
      end else begin
        if (sample_valid) begin
          dec_cnt <= accepted ? decim_l : dec_cnt - 1'b1;
        end
        if (accepted) begin
          prev       <= sample;
          prev_valid <= 1'b1;
        end
        if (accepted && (fsm inside {S_PRE, S_WAIT, S_POST})) begin
          wr_en   <= 1'b1;
          wr_addr <= ptr;
          wr_data <= sample;
          ptr     <= ptr + 1'b1;
        end

        unique case (fsm)
          S_PRE: begin
            if (force_trig) force_pending <= 1'b1;
            if (accepted) pre_cnt <= pre_cnt + 1'b1;
            // pretrig == 0 leaves PRE after a single cycle.
            if ((pre_cnt == pretrig_l) ||
                (accepted && (pre_cnt + 1'b1 == pretrig_l))) begin
              fsm <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (is_trig) begin
              force_pending <= 1'b0;
              trig_addr     <= ptr;
              start_addr    <= ptr - pretrig_l;
              post_cnt      <= ~pretrig_l;
              fsm           <= (pretrig_l == '1) ? S_DONE : S_POST;
            end else if (force_trig) begin
              force_pending <= 1'b1;
            end
          end
          S_POST: begin
            if (accepted) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == 1) fsm <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: a count-based record model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_scope_capture_ctrl;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 4;
  localparam int DEC_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              arm;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic [ADDR_W-1:0] pretrig;
  logic [DEC_W-1:0]  decim;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              done;
  logic [1:0]        state;

  scope_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
    .trig_rising(trig_rising), .pretrig(pretrig), .decim(decim),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trig_addr(trig_addr), .start_addr(start_addr),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the record is described by counts of writes since arm, not by states.
  int m_armed, m_first, m_done, m_trig, m_w, m_pre, m_dec, m_k;
  int m_pv, m_prev, m_fp, m_post_left;
  int e_wr_en, e_wr_addr, e_wr_data, e_trig, e_start, e_state, e_busy, e_done;

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrapd(input int v);
    return ((v % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic m_write(input int s);
    e_wr_en   = 1;
    e_wr_addr = wrapd(m_w);
    e_wr_data = s;
    m_w++;
  endtask

  task automatic model_step();
    int  s, lvl;
    bit  acc, active, edge_ok;
    if (rst) begin
      m_armed = 0; m_first = 0; m_done = 0; m_trig = 0; m_w = 0; m_pre = 0;
      m_dec = 0; m_k = 0; m_pv = 0; m_prev = 0; m_fp = 0; m_post_left = 0;
      e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_trig = 0; e_start = 0;
    end else if (arm) begin
      m_armed = 1; m_first = 1; m_done = 0; m_trig = 0; m_w = 0;
      m_pre = int'(pretrig); m_dec = int'(decim); m_k = 0; m_pv = 0; m_fp = 0;
      e_wr_en = 0;
    end else begin
      e_wr_en = 0;
      s   = sx(sample);
      lvl = sx(trig_level);
      acc = sample_valid && ((m_k % (m_dec + 1)) == 0);
      if (sample_valid) m_k++;
      active = m_armed && !m_done;
      if (active && !m_trig && (m_first || m_w < m_pre)) begin
        if (force_trig) m_fp = 1;
        if (acc) m_write(s);
      end else if (active && !m_trig) begin
        if (acc) begin
          edge_ok = m_pv && (trig_rising ? (m_prev < lvl && s >= lvl)
                                         : (m_prev > lvl && s <= lvl));
          if (m_fp || force_trig || edge_ok) begin
            e_trig      = wrapd(m_w);
            e_start     = wrapd(m_w - m_pre);
            m_trig      = 1;
            m_fp        = 0;
            m_post_left = DEPTH - 1 - m_pre;
            m_write(s);
            if (m_post_left == 0) m_done = 1;
          end else begin
            m_write(s);
          end
        end else if (force_trig) begin
          m_fp = 1;
        end
      end else if (active) begin
        if (acc) begin
          m_write(s);
          m_post_left--;
          if (m_post_left == 0) m_done = 1;
        end
      end
      if (acc) begin
        m_prev = s;
        m_pv   = 1;
      end
      m_first = 0;
    end
    e_done  = m_done;
    e_busy  = m_armed && !m_done;
    e_state = !e_busy ? 0 : m_trig ? 3 : (m_first || m_w < m_pre) ? 1 : 2;
  endtask

  // Observed DUT writes since the last arm, plus what happened when done rose.
  int wl_addr[$];
  int wl_data[$];
  int img[DEPTH];
  logic prev_done = 1'b0;
  int d_wr_en, d_addr, d_data;

  task automatic compare();
    check("state", state, e_state);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("wr_en", wr_en, e_wr_en);
    check("trig_addr", trig_addr, e_trig);
    check("start_addr", start_addr, e_start);
    if (e_wr_en != 0) begin
      check("wr_addr", wr_addr, e_wr_addr);
      check("wr_data", sx(wr_data), e_wr_data);
    end
    if (wr_en === 1'b1) begin
      wl_addr.push_back(int'(wr_addr));
      wl_data.push_back(sx(wr_data));
      img[int'(wr_addr)] = sx(wr_data);
    end
    if (done === 1'b1 && prev_done !== 1'b1) begin
      d_wr_en = int'(wr_en);
      d_addr  = int'(wr_addr);
      d_data  = sx(wr_data);
    end
    prev_done = done;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_arm(input int pt, input int dc);
    pretrig      = ADDR_W'(pt);
    decim        = DEC_W'(dc);
    arm          = 1'b1;
    sample_valid = 1'b0;
    force_trig   = 1'b0;
    tick();
    arm = 1'b0;
    wl_addr.delete();
    wl_data.delete();
    d_wr_en = -1; d_addr = -1; d_data = -999;
  endtask

  // Feeds base + step*i (optionally wrapped to -8..7), one strobe per `spacing`
  // cycles, pulsing force at cycle force_cyc; stops when done rises.
  task automatic feed(input int base, input int step, input bit wrap16,
                      input int spacing, input int force_cyc, input int max_cyc,
                      input bit expect_done, input string name);
    int idx = 0;
    int v;
    for (int c = 0; c < max_cyc; c++) begin
      sample_valid = (c % spacing) == 0;
      v = base + step * idx;
      if (wrap16) v = ((v + 8) & 15) - 8;
      sample     = DATA_W'(v);
      force_trig = (c == force_cyc);
      if (sample_valid) idx++;
      tick();
      if (done === 1'b1) break;
    end
    sample_valid = 1'b0;
    force_trig   = 1'b0;
    if (expect_done) check({name, "_done"}, done, 1);
  endtask

  initial begin
    int wcnt;
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0; sample_valid = 1'b0;
    sample = '0; trig_level = '0; trig_rising = 1'b1; pretrig = '0; decim = '0;

    // Reset held 3 cycles under random inputs.
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'($urandom);
      sample       = DATA_W'($urandom);
      arm          = 1'($urandom);
      force_trig   = 1'($urandom);
      pretrig      = ADDR_W'($urandom);
      tick();
    end
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_trig_addr", trig_addr, 0);
    rst = 1'b0; arm = 1'b0; force_trig = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1'($urandom);
      sample       = DATA_W'($urandom);
      tick();
      if (wr_en === 1'b1) wcnt++;
    end
    check("idle_no_writes", wcnt, 0);

    // Rising ramp, pretrig 4, level 0, one strobe every 3 cycles.
    trig_level = DATA_W'(0); trig_rising = 1'b1;
    do_arm(4, 0);
    feed(-8, 1, 1'b1, 3, -1, 200, 1'b1, "ramp");
    check("ramp_trig_addr", trig_addr, 8);
    check("ramp_start_addr", start_addr, 4);
    check("ramp_zero_at_8", img[8], 0);
    check("ramp_writes", wl_addr.size(), 20);
    check("ramp_last_addr", wl_addr[wl_addr.size()-1], 3);
    check("ramp_last_data", wl_data[wl_data.size()-1], -5);
    check("ramp_done_with_write", d_wr_en, 1);
    check("ramp_done_addr", d_addr, 3);

    // Force pulse during PRE with an unreachable level.
    trig_level = DATA_W'(100);
    do_arm(4, 0);
    feed(-8, 1, 1'b1, 3, 1, 200, 1'b1, "force");
    check("force_trig_addr", trig_addr, 4);
    check("force_start_addr", start_addr, 0);

    // Decimation by 3 with back-to-back strobes.
    trig_level = DATA_W'(8000);
    do_arm(4, 2);
    feed(0, 1, 1'b0, 1, -1, 30, 1'b0, "decim");
    check("decim_writes", wl_addr.size(), 10);
    check("decim_w0_data", wl_data[0], 0);
    check("decim_w1_data", wl_data[1], 3);
    check("decim_w2_data", wl_data[2], 6);
    check("decim_w2_addr", wl_addr[2], 2);

    // Falling edge hitting the level exactly, then re-arm mid-POST.
    trig_level = DATA_W'(5); trig_rising = 1'b0;
    do_arm(2, 0);
    feed(7, -1, 1'b0, 2, -1, 12, 1'b0, "fall");
    check("fall_trig_addr", trig_addr, 2);
    check("fall_trig_data", img[2], 5);
    check("fall_in_post", state, 3);
    do_arm(3, 0);
    check("rearm_done", done, 0);
    check("rearm_state", state, 1);
    trig_level = DATA_W'(0); trig_rising = 1'b1;
    feed(-8, 1, 1'b1, 2, -1, 200, 1'b1, "rearm");
    check("rearm_first_addr", wl_addr[0], 0);
    check("rearm_trig_addr", trig_addr, 8);
    check("rearm_start_addr", start_addr, 5);

    // pretrig = DEPTH-1: record completes on the trigger write.
    trig_level = DATA_W'(8000);
    do_arm(15, 0);
    feed(0, 1, 1'b0, 1, 20, 100, 1'b1, "pt15");
    check("pt15_trig_addr", trig_addr, 4);
    check("pt15_start_addr", start_addr, 5);
    check("pt15_done_with_write", d_wr_en, 1);
    check("pt15_done_addr", d_addr, 4);

    // pretrig = 0: start equals trigger.
    trig_level = DATA_W'(0);
    do_arm(0, 0);
    feed(-8, 1, 1'b1, 1, -1, 100, 1'b1, "pt0");
    check("pt0_trig_addr", trig_addr, 8);
    check("pt0_start_addr", start_addr, 8);

    // Randomized traffic against the model.
    for (int r = 0; r < 8; r++) begin
      trig_level  = DATA_W'($urandom_range(40) - 20);
      trig_rising = 1'($urandom);
      do_arm($urandom_range(DEPTH - 1), $urandom_range(3));
      for (int c = 0; c < 600; c++) begin
        rst          = ($urandom_range(1499) == 0);
        arm          = ($urandom_range(399) == 0);
        force_trig   = ($urandom_range(79) == 0);
        sample_valid = ($urandom_range(9) < 6);
        sample       = DATA_W'($urandom_range(63) - 32);
        pretrig      = ADDR_W'($urandom);
        decim        = DEC_W'($urandom_range(3));
        tick();
      end
      rst = 1'b0; arm = 1'b0; force_trig = 1'b0; sample_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
